dx_hazard_ctrl: RTL and testbench
=================================

// Module: dx_hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller sitting at the D/X boundary, feeding the X-stage bypass
//  muxes. Detects load-use hazards (stall F/D + D/X, inject nop into X) and sequences the
//  multicycle mult/div unit (start pulse, hold pipeline until ready, timeout guard).
//  Taken-branch squash from X is folded in so one block owns every stall/flush signal.
// PARAMETERS
//  MD_TIMEOUT  64  max RUN cycles awaiting md_rdy before abort; counter width $clog2(MD_TIMEOUT+1)
// PORTS
//  clock       in   1   pipeline clock, rising edge
//  reset       in   1   asynchronous, active-low; all state cleared while low
//  fd_insn     in   32  instruction in F/D latch (opcode [31:27], rd [26:22], rs [21:17], rt [16:12])
//  dx_insn     in   32  instruction in D/X latch
//  br_taken    in   1   X stage resolved taken branch/jump this cycle
//  md_rdy      in   1   mult/div result valid (single-cycle pulse)
//  stall_fd    out  1   hold F/D latch and PC
//  stall_dx    out  1   hold D/X latch
//  flush_fd    out  1   load nop into F/D
//  flush_dx    out  1   load nop into D/X
//  md_start    out  1   one-cycle start pulse to mult/div
//  md_busy     out  1   FSM in RUN
//  md_timeout  out  1   sticky: a RUN aborted on timeout; cleared only by reset
// BEHAVIOUR
//  Source decode of fd_insn (sub-module): R-type 00000 -> rs,rt; addi 00101/lw 01000 -> rs;
//   sw 00111, bne 00010, blt 00110 -> rd,rs; jr 00100 -> rd; bex 10110 -> r30; others none.
//  Load-use: dx opcode==01000 && dx rd!=0 && (rd==srcA || rd==srcB) -> luse=1.
//  Mult/div: dx opcode 00000 && aluop [6:2] in {00110 mul, 00111 div} -> is_md.
//  FSM states IDLE, RUN, DONE (reset -> IDLE):
//   IDLE: is_md -> md_start=1, stall_fd=stall_dx=1, -> RUN, tmo_cnt<=0.
//   RUN : md_busy=1, stalls=1; md_rdy -> DONE; else tmo_cnt==MD_TIMEOUT-1 -> md_timeout<=1, -> DONE;
//         else tmo_cnt++.
//   DONE: no md stall (D/X advances, mul leaves X); is_md ignored this cycle; -> IDLE.
//  md_rdy outside RUN ignored. Back-to-back mul: second mul enters DX in the cycle after DONE, restarts from IDLE.
//  Priority (comb. outputs from state + inputs):
//   1 br_taken: flush_fd=flush_dx=1, no load-use stall (FD squashed); never coincides with md stall.
//   2 md stall (IDLE-detect or RUN): stall_fd=stall_dx=1, flush_dx=0, load-use suppressed.
//   3 luse: stall_fd=1, stall_dx=0, flush_dx=1 (bubble); resolves next cycle as lw moves to M.
//  Reset values: all outputs 0, state IDLE, counters 0. Reset low mid-RUN aborts to IDLE with no
//   md_start on release unless is_md is sampled again in IDLE.
// CONFIGURATION
//  STALL_COUNT_EN defined: adds outputs stall_cycles[31:0], md_cycles[31:0]; stall_cycles++ each
//   cycle stall_fd=1, md_cycles++ each RUN cycle; both wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package/header: opcode consts (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BNE, OP_BLT, OP_JR,
//   OP_BEX), ALUOP_MUL/ALUOP_DIV, REG_STATUS=30, FSM state encodings.
//  One sub-module: insn_src_regs (insn -> srcA, srcB, useA, useB), pure combinational.
// TESTING
//  lw r5 in DX, add r1,r5,r2 in FD -> stall_fd=1, flush_dx=1, stall_dx=0 one cycle; next cycle all 0.
//  lw r0 in DX, FD reads r0 -> no stall; lw r5 + sw r5,0(r3) in FD -> stall (rd used as source).
//  mul in DX, md_rdy after 32 cycles -> md_start pulse cycle 0, stalls high 33 cycles, DONE releases.
//  mul, md_rdy never -> md_timeout=1 after 64 RUN cycles, FSM returns IDLE; reset low clears it.
//  br_taken with load-use pending -> flush_fd=flush_dx=1, stall_fd=0.
//  reset low mid-RUN -> outputs 0 immediately (async); STALL_COUNT_EN build: counters match cycles.

Source files
------------

// File: rtl/dx_hazard_ctrl_pkg.sv
// Shared definitions for the D/X hazard controller: opcode and ALU-op constants,
// the status register index, and the mult/div sequencer state encoding.
package dx_hazard_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } md_state_e;

    // R-type instruction whose ALU op selects the multicycle unit.
    function automatic logic is_md_op(logic [4:0] op, logic [4:0] aluop);
        return (op == OP_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/dx_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the master, the
// controller the slave. Build option STALL_COUNT_EN adds the two performance counters.
interface dx_hazard_ctrl_if;

    logic [31:0] fd_insn;
    logic [31:0] dx_insn;
    logic        br_taken;
    logic        md_rdy;
    logic        stall_fd;
    logic        stall_dx;
    logic        flush_fd;
    logic        flush_dx;
    logic        md_start;
    logic        md_busy;
    logic        md_timeout;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] md_cycles;
`endif

    modport master (
        output fd_insn, dx_insn, br_taken, md_rdy,
        input  stall_fd, stall_dx, flush_fd, flush_dx, md_start, md_busy, md_timeout
`ifdef STALL_COUNT_EN
        , input stall_cycles, md_cycles
`endif
    );

    modport slave (
        input  fd_insn, dx_insn, br_taken, md_rdy,
        output stall_fd, stall_dx, flush_fd, flush_dx, md_start, md_busy, md_timeout
`ifdef STALL_COUNT_EN
        , output stall_cycles, md_cycles
`endif
    );

endinterface

// File: rtl/dx_hazard_ctrl_insn_src_regs.sv
// Source-register decode (insn_src_regs): which registers an instruction reads.
// Pure combinational.
module dx_hazard_ctrl_insn_src_regs
    import dx_hazard_ctrl_pkg::*;
(
    input  logic [31:0] insn,
    output logic [4:0]  src_a,
    output logic [4:0]  src_b,
    output logic        use_a,
    output logic        use_b
);

    logic [4:0] op, rd, rs, rt;
    logic       unused_insn;

    assign op = insn[31:27];
    assign rd = insn[26:22];
    assign rs = insn[21:17];
    assign rt = insn[16:12];
    assign unused_insn = ^insn[11:0];

    // Stores and branches read rd as a source, not a destination.
    always_comb begin
        src_a = '0;
        src_b = '0;
        use_a = 1'b0;
        use_b = 1'b0;
        case (op)
            OP_RTYPE: begin
                src_a = rs; use_a = 1'b1;
                src_b = rt; use_b = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                src_a = rs; use_a = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a = rd; use_a = 1'b1;
                src_b = rs; use_b = 1'b1;
            end
            OP_JR: begin
                src_a = rd; use_a = 1'b1;
            end
            OP_BEX: begin
                src_a = REG_STATUS; use_a = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dx_hazard_ctrl.sv
// D/X hazard and stall controller: load-use bubbles, mult/div sequencing with timeout,
// and taken-branch squash. Optional build macro STALL_COUNT_EN adds stall_cycles and
// md_cycles counters on the interface.
module dx_hazard_ctrl
    import dx_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input logic            clock,
    input logic            reset,
    dx_hazard_ctrl_if.slave bus
);

    localparam int unsigned TmoW = $clog2(MD_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MD_TIMEOUT - 1);

    logic [4:0] src_a, src_b;
    logic       use_a, use_b;

    dx_hazard_ctrl_insn_src_regs u_src_regs (
        .insn  (bus.fd_insn),
        .src_a (src_a),
        .src_b (src_b),
        .use_a (use_a),
        .use_b (use_b)
    );

    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       unused_dx;
    logic       luse, is_md;

    assign dx_op     = bus.dx_insn[31:27];
    assign dx_rd     = bus.dx_insn[26:22];
    assign dx_aluop  = bus.dx_insn[6:2];
    assign unused_dx = ^{bus.dx_insn[21:7], bus.dx_insn[1:0]};

    assign luse  = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                   ((use_a && (dx_rd == src_a)) || (use_b && (dx_rd == src_b)));
    assign is_md = is_md_op(dx_op, dx_aluop);

    md_state_e       state_q, state_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;
    logic            md_start_c, md_busy_c, md_stall_c;

    // Mult/div sequencer next state; a mul about to be squashed by a branch is not started.
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_d      = tmo_q;
        md_start_c = 1'b0;
        md_busy_c  = 1'b0;
        md_stall_c = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_md && !bus.br_taken) begin
                    md_start_c = 1'b1;
                    md_stall_c = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                md_busy_c  = 1'b1;
                md_stall_c = 1'b1;
                if (bus.md_rdy) begin
                    state_d = StDone;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            // The finished mul leaves X this cycle; it must not retrigger.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state; reset aborts any run in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    logic stall_fd_c, stall_dx_c, flush_fd_c, flush_dx_c;

    // Prioritised stall/flush outputs; everything is forced low while reset is held.
    always_comb begin
        stall_fd_c = 1'b0;
        stall_dx_c = 1'b0;
        flush_fd_c = 1'b0;
        flush_dx_c = 1'b0;
        if (reset) begin
            if (bus.br_taken) begin
                flush_fd_c = 1'b1;
                flush_dx_c = 1'b1;
            end else if (md_stall_c) begin
                stall_fd_c = 1'b1;
                stall_dx_c = 1'b1;
            end else if (luse) begin
                stall_fd_c = 1'b1;
                flush_dx_c = 1'b1;
            end
        end
    end

    assign bus.stall_fd   = stall_fd_c;
    assign bus.stall_dx   = stall_dx_c;
    assign bus.flush_fd   = flush_fd_c;
    assign bus.flush_dx   = flush_dx_c;
    assign bus.md_start   = reset & md_start_c;
    assign bus.md_busy    = reset & md_busy_c;
    assign bus.md_timeout = reset & tmo_q;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles_q, md_cycles_q;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            md_cycles_q    <= '0;
        end else begin
            if (stall_fd_c)       stall_cycles_q <= stall_cycles_q + 32'd1;
            if (state_q == StRun) md_cycles_q    <= md_cycles_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.md_cycles    = md_cycles_q;
`endif

endmodule

// File: tb/tb_dx_hazard_ctrl.sv
// Bench for dx_hazard_ctrl: directed hazard/mult-div/reset scenarios then randomized
// instruction streams, compared every cycle against a behavioural model.
module tb_dx_hazard_ctrl;

    localparam int TMO = 64;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dx_hazard_ctrl_if bus ();

    dx_hazard_ctrl #(.MD_TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state
    bit          m_run;
    int          m_wait;
    bit          m_cool;
    bit          m_tmo;
    int unsigned m_sc;
    int unsigned m_mc;
    int          obs_stalls;

    function automatic logic [31:0] enc(int op, int rd, int rs, int rt, int alu);
        return {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, alu[4:0], 2'b00};
    endfunction

    // Does insn read register r?
    function automatic bit reads(logic [31:0] insn, logic [4:0] r);
        logic [4:0] rd, rs, rt;
        rd = insn[26:22]; rs = insn[21:17]; rt = insn[16:12];
        case (int'(insn[31:27]))
            0:       return (r == rs) || (r == rt);
            5, 8:    return r == rs;
            7, 2, 6: return (r == rd) || (r == rs);
            4:       return r == rd;
            22:      return r == 5'd30;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_mul(logic [31:0] insn);
        return (insn[31:27] == 5'd0) && (insn[6:2] == 5'd6 || insn[6:2] == 5'd7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_cool = 0; m_tmo = 0; m_sc = 0; m_mc = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall_fd"}, {31'd0, bus.stall_fd}, 0);
        chk({tag, "_stall_dx"}, {31'd0, bus.stall_dx}, 0);
        chk({tag, "_flush_fd"}, {31'd0, bus.flush_fd}, 0);
        chk({tag, "_flush_dx"}, {31'd0, bus.flush_dx}, 0);
        chk({tag, "_md_start"}, {31'd0, bus.md_start}, 0);
        chk({tag, "_md_busy"}, {31'd0, bus.md_busy}, 0);
        chk({tag, "_md_timeout"}, {31'd0, bus.md_timeout}, 0);
`ifdef STALL_COUNT_EN
        chk({tag, "_stall_cycles"}, bus.stall_cycles, 0);
        chk({tag, "_md_cycles"}, bus.md_cycles, 0);
`endif
    endtask

    // One pipeline cycle: drive, check mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                         input bit br, input bit rdy);
        bit lu, md, start, mds;
        bit e_sfd, e_sdx, e_ffd, e_fdx;
        bus.fd_insn  = fd;
        bus.dx_insn  = dx;
        bus.br_taken = br;
        bus.md_rdy   = rdy;
        @(negedge clock);
        lu    = (dx[31:27] == 5'd8) && (dx[26:22] != 5'd0) && reads(fd, dx[26:22]);
        md    = is_mul(dx);
        start = !m_run && !m_cool && md && !br;
        mds   = m_run || start;
        e_sfd = !br && (mds || lu);
        e_sdx = !br && mds;
        e_ffd = br;
        e_fdx = br || (!mds && lu);
        chk({tag, "_stall_fd"}, {31'd0, bus.stall_fd}, {31'd0, e_sfd});
        chk({tag, "_stall_dx"}, {31'd0, bus.stall_dx}, {31'd0, e_sdx});
        chk({tag, "_flush_fd"}, {31'd0, bus.flush_fd}, {31'd0, e_ffd});
        chk({tag, "_flush_dx"}, {31'd0, bus.flush_dx}, {31'd0, e_fdx});
        chk({tag, "_md_start"}, {31'd0, bus.md_start}, {31'd0, start});
        chk({tag, "_md_busy"}, {31'd0, bus.md_busy}, {31'd0, m_run});
        chk({tag, "_md_timeout"}, {31'd0, bus.md_timeout}, {31'd0, m_tmo});
`ifdef STALL_COUNT_EN
        chk({tag, "_stall_cycles"}, bus.stall_cycles, m_sc);
        chk({tag, "_md_cycles"}, bus.md_cycles, m_mc);
`endif
        if (bus.stall_fd === 1'b1) obs_stalls++;
        @(posedge clock);
        m_sc += int'(e_sfd);
        m_mc += int'(m_run);
        if (m_run) begin
            if (rdy) begin
                m_run = 0; m_cool = 1;
            end else if (m_wait == TMO - 1) begin
                m_run = 0; m_cool = 1; m_tmo = 1;
            end else begin
                m_wait++;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (start) begin
            m_run = 1; m_wait = 0;
        end
        #1;
    endtask

    logic [31:0] LW_R5, ADD_R5, NOP, LW_R0, ADD_R0, SW_R5, MUL, LW_R30, BEX, DIV;

    initial begin
        int ops[8] = '{0, 5, 8, 7, 2, 6, 4, 22};
        int alus[4] = '{0, 6, 7, 1};
        logic [31:0] rfd, rdx;
        bit rbr, rrdy;

        LW_R5  = enc(8, 5, 3, 0, 0);
        ADD_R5 = enc(0, 1, 5, 2, 0);
        NOP    = 32'd0;
        LW_R0  = enc(8, 0, 3, 0, 0);
        ADD_R0 = enc(0, 1, 0, 0, 0);
        SW_R5  = enc(7, 5, 3, 0, 0);
        MUL    = enc(0, 4, 6, 7, 6);
        DIV    = enc(0, 4, 6, 7, 7);
        LW_R30 = enc(8, 30, 1, 0, 0);
        BEX    = enc(22, 0, 0, 0, 0);

        // Reset with a load-use hazard on the inputs: outputs still low.
        reset = 1'b0;
        bus.fd_insn = ADD_R5; bus.dx_insn = LW_R5; bus.br_taken = 1'b0; bus.md_rdy = 1'b0;
        model_reset();
        #3 chk_zero("rst");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Load-use bubble, then resolved.
        cycle("luse", ADD_R5, LW_R5, 0, 0);
        cycle("luse_next", ADD_R5, NOP, 0, 0);
        cycle("lw_r0", ADD_R0, LW_R0, 0, 0);
        cycle("lw_sw", SW_R5, LW_R5, 0, 0);
        cycle("lw_bex", BEX, LW_R30, 0, 0);
        cycle("br_luse", ADD_R5, LW_R5, 1, 0);

        // Mul with result after 32 RUN cycles: 33 stall cycles, DONE releases.
        obs_stalls = 0;
        for (int i = 0; i < 34; i++) cycle("mul", ADD_R5, MUL, 0, i == 32);
        chk("mul_stall_len", obs_stalls, 33);
        cycle("mul_after", ADD_R5, NOP, 0, 0);

        // Div that never completes: timeout after 64 RUN cycles, sticky.
        obs_stalls = 0;
        for (int i = 0; i < 66; i++) cycle("tmo", NOP, DIV, 0, 0);
        chk("tmo_stall_len", obs_stalls, 65);
        cycle("tmo_sticky", NOP, NOP, 0, 1);
        chk("tmo_flag", {31'd0, bus.md_timeout}, 1);
        reset = 1'b0;
        model_reset();
        #1 chk_zero("tmo_rst");
        @(posedge clock);
        #1 reset = 1'b1;

        // Reset mid-RUN with mul still in D/X: async clear, then restart from IDLE.
        for (int i = 0; i < 5; i++) cycle("midrun", NOP, MUL, 0, 0);
        #2 reset = 1'b0;
        model_reset();
        #1 chk_zero("midrun_rst");
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle("midrun_restart", NOP, MUL, 0, i == 2);
        cycle("midrun_done", NOP, MUL, 0, 0);
        cycle("b2b_mul", NOP, MUL, 0, 0);
        cycle("b2b_run", NOP, MUL, 0, 1);
        cycle("b2b_done", NOP, NOP, 0, 0);

        // Randomized instruction streams.
        for (int i = 0; i < 400; i++) begin
            rfd = enc(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), alus[$urandom_range(0, 3)]);
            if ($urandom_range(0, 2) == 0)
                rdx = enc(8, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
            else
                rdx = enc(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), alus[$urandom_range(0, 3)]);
            rbr  = (!m_run && !(is_mul(rdx) && !m_cool)) ? ($urandom_range(0, 5) == 0) : 1'b0;
            rrdy = ($urandom_range(0, 15) == 0);
            cycle("rand", rfd, rdx, rbr, rrdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
